// File: rtl/aqua_rx_comandos.sv
// Aqua station serial command receiver: 8N1 UART deserialiser plus
// "#<c>\n" command parser producing one-cycle control pulses.
module aqua_rx_comandos #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dado,
    output logic       dado_valido,
    output logic       erro_quadro,
    output logic       erro_comando,
    output logic       iniciar,
    output logic       abre,
    output logic       fecha,
    output logic       reinicia,
    output logic [3:0] db_estado
);

    localparam int CICLOS_BIT = CLK_FREQ / BAUD;
    localparam int MEIO_BIT   = CICLOS_BIT / 2;
    localparam int CW         = $clog2(CICLOS_BIT + 1);

    localparam logic [CW-1:0] FIM_BIT  = CW'(CICLOS_BIT - 1);
    localparam logic [CW-1:0] FIM_MEIO = CW'(MEIO_BIT - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        START  = 2'b01,
        DADOS  = 2'b10,
        STOP   = 2'b11
    } rx_t;

    typedef enum logic [1:0] {
        ESPERA_INICIO = 2'b00,
        ESPERA_CMD    = 2'b01,
        ESPERA_FIM    = 2'b10
    } par_t;

    rx_t           rx_estado, rx_prox;
    par_t          p_estado, p_prox;
    logic          rx_m, rx_s;
    logic [1:0]    aquec;
    logic          armado;
    logic [CW-1:0] cnt;
    logic [2:0]    nbits;
    logic [7:0]    shift;
    logic          fim_cnt;
    logic          amostra_dado, amostra_stop;
    logic [3:0]    cmd, cmd_prox, oh;
    logic [3:0]    pulsos_prox;
    logic          erro_prox;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Arm start detection only once a real idle level has been seen
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aquec  <= 2'd0;
            armado <= 1'b0;
        end else begin
            if (aquec != 2'd2)
                aquec <= aquec + 2'd1;
            if (amostra_stop && !rx_s)
                armado <= 1'b0;
            else if (aquec == 2'd2 && rx_s)
                armado <= 1'b1;
        end
    end

    assign fim_cnt = (rx_estado == START) ? (cnt == FIM_MEIO)
                                          : (cnt == FIM_BIT);

    // RX state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rx_estado <= OCIOSO;
        else
            rx_estado <= rx_prox;
    end

    // RX next-state logic
    always_comb begin
        rx_prox = rx_estado;
        unique case (rx_estado)
            OCIOSO: if (armado && !rx_s) rx_prox = START;
            START:  if (fim_cnt) rx_prox = rx_s ? OCIOSO : DADOS;
            DADOS:  if (fim_cnt && nbits == 3'd7) rx_prox = STOP;
            STOP:   if (fim_cnt) rx_prox = OCIOSO;
        endcase
    end

    // RX sampling strobes
    always_comb begin
        amostra_dado = (rx_estado == DADOS) && fim_cnt;
        amostra_stop = (rx_estado == STOP) && fim_cnt;
    end

    // Bit timing counter, shift register and registered RX pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            nbits       <= 3'd0;
            shift       <= 8'h00;
            dado        <= 8'h00;
            dado_valido <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            dado_valido <= 1'b0;
            erro_quadro <= 1'b0;
            if (rx_estado == OCIOSO) begin
                cnt   <= '0;
                nbits <= 3'd0;
            end else if (fim_cnt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (amostra_dado) begin
                shift <= {rx_s, shift[7:1]};
                nbits <= nbits + 3'd1;
            end
            if (amostra_stop) begin
                if (rx_s) begin
                    dado        <= shift;
                    dado_valido <= 1'b1;
                end else begin
                    erro_quadro <= 1'b1;
                end
            end
        end
    end

    // One-hot {reinicia, fecha, abre, iniciar} for an accepted command letter
    always_comb begin
        oh = 4'b0000;
        unique case (dado)
            8'h49:   oh = 4'b0001;
            8'h41:   oh = 4'b0010;
            8'h46:   oh = 4'b0100;
            8'h52:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
    end

    // Parser state, latched command and registered command pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_estado     <= ESPERA_INICIO;
            cmd          <= 4'b0000;
            erro_comando <= 1'b0;
            {reinicia, fecha, abre, iniciar} <= 4'b0000;
        end else begin
            p_estado     <= p_prox;
            cmd          <= cmd_prox;
            erro_comando <= erro_prox;
            {reinicia, fecha, abre, iniciar} <= pulsos_prox;
        end
    end

    // Parser next-state and pulse decision on each received byte
    always_comb begin
        p_prox      = p_estado;
        cmd_prox    = cmd;
        pulsos_prox = 4'b0000;
        erro_prox   = 1'b0;
        if (erro_quadro) begin
            p_prox   = ESPERA_INICIO;
            cmd_prox = 4'b0000;
        end else if (dado_valido) begin
            unique case (p_estado)
                ESPERA_INICIO: begin
                    if (dado == 8'h23)
                        p_prox = ESPERA_CMD;
                end
                ESPERA_CMD: begin
                    if (oh != 4'b0000) begin
                        cmd_prox = oh;
                        p_prox   = ESPERA_FIM;
                    end else if (dado != 8'h23) begin
                        erro_prox = 1'b1;
                        p_prox    = ESPERA_INICIO;
                    end
                end
                ESPERA_FIM: begin
                    if (dado == 8'h0A) begin
                        pulsos_prox = cmd;
                        p_prox      = ESPERA_INICIO;
                    end else begin
                        erro_prox = 1'b1;
                        p_prox    = (dado == 8'h23) ? ESPERA_CMD
                                                    : ESPERA_INICIO;
                    end
                end
                default: p_prox = ESPERA_INICIO;
            endcase
        end
    end

    assign db_estado = {p_estado, rx_estado};

endmodule
